// File: rtl/mem_access_pkg.sv
// Shared types for the memory stage: pipeline bundles, data-bus request/response,
// decoded op encoding and the access-controller state enum.
package mem_access_pkg;

    localparam int unsigned XLEN = 64;

    typedef logic [XLEN-1:0] u64;

    typedef enum logic [4:0] {
        UNKNOWN, ADD, SUB, SLL, LUI,
        LB, LBU, LH, LHU, LW, LWU, LD,
        SB, SH, SW, SD
    } decoded_op_t;

    typedef enum logic [2:0] {
        MSIZE1, MSIZE2, MSIZE4, MSIZE8
    } msize_t;

    typedef enum logic [1:0] {
        IDLE, REQ, DONE, DRAIN
    } mem_state_t;

    typedef struct packed {
        decoded_op_t op;
        logic        regwrite;
    } control_t;

    typedef struct packed {
        u64          pc;
        u64          result;
        u64          mem_addr;
        control_t    ctl;
        logic [4:0]  dst;
        logic        stall;
    } execute_data_t;

    typedef struct packed {
        u64          pc;
        u64          result;
        control_t    ctl;
        logic [4:0]  dst;
        logic        stall;
    } memory_data_t;

    typedef struct packed {
        logic        valid;
        u64          addr;
        msize_t      size;
        logic [7:0]  strobe;
        u64          data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        u64          data;
    } dbus_resp_t;

    function automatic logic is_load(decoded_op_t op);
        return op inside {LB, LBU, LH, LHU, LW, LWU, LD};
    endfunction

    function automatic logic is_store(decoded_op_t op);
        return op inside {SB, SH, SW, SD};
    endfunction

    function automatic logic is_mem_op(decoded_op_t op);
        return is_load(op) || is_store(op);
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus port bundle: request driven by the memory stage, response by the bus.
interface mem_access_if;
    import mem_access_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/mem_access_align.sv
// Byte-lane shaping: store size/strobe/data placement and load extraction/extension.
module mem_align
    import mem_access_pkg::*;
(
    input  decoded_op_t i_op,
    input  logic [2:0]  i_off,
    input  u64          i_store_data,
    input  u64          i_load_raw,
    output msize_t      o_size,
    output logic [7:0]  o_strobe,
    output u64          o_store_data,
    output u64          o_load_data
);
    logic [5:0] w_shamt;
    logic [7:0] w_mask;
    u64         w_raw;

    assign w_shamt = {i_off, 3'b000};

    always_comb begin
        o_size = MSIZE8;
        w_mask = 8'hff;
        case (i_op)
            LB, LBU, SB: begin o_size = MSIZE1; w_mask = 8'h01; end
            LH, LHU, SH: begin o_size = MSIZE2; w_mask = 8'h03; end
            LW, LWU, SW: begin o_size = MSIZE4; w_mask = 8'h0f; end
            default:     begin o_size = MSIZE8; w_mask = 8'hff; end
        endcase

        o_strobe     = is_store(i_op) ? (w_mask << i_off) : '0;
        o_store_data = is_store(i_op) ? (i_store_data << w_shamt) : '0;

        w_raw = i_load_raw >> w_shamt;
        case (i_op)
            LB:      o_load_data = {{56{w_raw[7]}},  w_raw[7:0]};
            LBU:     o_load_data = {56'b0,           w_raw[7:0]};
            LH:      o_load_data = {{48{w_raw[15]}}, w_raw[15:0]};
            LHU:     o_load_data = {48'b0,           w_raw[15:0]};
            LW:      o_load_data = {{32{w_raw[31]}}, w_raw[31:0]};
            LWU:     o_load_data = {32'b0,           w_raw[31:0]};
            default: o_load_data = w_raw;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// Memory-stage access controller: issues loads/stores on the data bus, stalls the
// pipeline while a transaction is outstanding and produces the MEM/WB bundle.
module mem_access
    import mem_access_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          flush,
    input  logic          stall_other,
    mem_access_if.master  dbus,
    output memory_data_t  dataM,
    output logic          stallM
);
    mem_state_t    r_state, w_next;
    execute_data_t r_held;
    memory_data_t  r_done;

    execute_data_t w_cur;
    memory_data_t  w_cap;
    dbus_req_t     w_req;
    logic          w_is_mem, w_issue, w_capture;
    msize_t        w_size;
    logic [7:0]    w_strobe;
    u64            w_sdata, w_ldata;

    // Once the request is out, the bus is fed from the held copy so a flushed or
    // replaced EX/MEM register cannot disturb an outstanding transaction.
    assign w_cur     = (r_state == IDLE) ? dataE : r_held;
    assign w_is_mem  = is_mem_op(w_cur.ctl.op) && !w_cur.stall;
    assign w_issue   = (r_state == IDLE) && w_is_mem && !flush;
    assign w_capture = dbus.dresp.data_ok && (w_issue || (r_state == REQ));

    mem_align u_align (
        .i_op         (w_cur.ctl.op),
        .i_off        (w_cur.mem_addr[2:0]),
        .i_store_data (w_cur.result),
        .i_load_raw   (dbus.dresp.data),
        .o_size       (w_size),
        .o_strobe     (w_strobe),
        .o_store_data (w_sdata),
        .o_load_data  (w_ldata)
    );

    always_comb begin
        w_req = '{valid: 1'b1, addr: w_cur.mem_addr, size: w_size,
                  strobe: w_strobe, data: w_sdata};
        w_cap = '{pc: w_cur.pc,
                  result: is_load(w_cur.ctl.op) ? w_ldata : '0,
                  ctl: w_cur.ctl, dst: w_cur.dst, stall: 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_held  <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE)
                r_held <= dataE;
            if (w_capture)
                r_done <= w_cap;
        end
    end

    always_comb begin
        w_next    = r_state;
        stallM    = 1'b0;
        dbus.dreq = '0;
        dataM     = '{pc: dataE.pc, result: dataE.result, ctl: dataE.ctl,
                      dst: dataE.dst, stall: dataE.stall};
        case (r_state)
            IDLE: begin
                if (w_is_mem) begin
                    dataM.stall        = 1'b1;
                    dataM.ctl.regwrite = 1'b0;
                end
                if (w_issue) begin
                    dbus.dreq = w_req;
                    stallM    = 1'b1;
                    w_next    = dbus.dresp.data_ok ? DONE : REQ;
                end
            end
            REQ: begin
                dbus.dreq          = w_req;
                stallM             = 1'b1;
                dataM.stall        = 1'b1;
                dataM.ctl.regwrite = 1'b0;
                if (dbus.dresp.data_ok)
                    w_next = flush ? IDLE : DONE;
                else if (flush)
                    w_next = DRAIN;
            end
            DONE: begin
                dataM = r_done;
                if (flush || !stall_other)
                    w_next = IDLE;
            end
            DRAIN: begin
                dbus.dreq          = w_req;
                stallM             = 1'b1;
                dataM.stall        = 1'b1;
                dataM.ctl.regwrite = 1'b0;
                if (dbus.dresp.data_ok)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase

        if (flush) begin
            dataM.stall        = 1'b1;
            dataM.ctl.regwrite = 1'b0;
        end
        if (reset) begin
            dbus.dreq   = '0;
            stallM      = 1'b0;
            dataM       = '0;
            dataM.stall = 1'b1;
            w_next      = IDLE;
        end
    end
endmodule
